spi_sample_rx: RTL
==================

// Module: spi_sample_rx
// PURPOSE
//  SPI slave (mode 0, MSB first) that receives 11-bit sign-magnitude audio frames
//  from an FPGA SPI master that shifts out the effects chain's output sample.
//  Oversamples the asynchronous sclk/ncs/mosi pins on the 40 MHz clk.
//  Outputs each good sample (raw, plus an 11-bit offset-binary DAC code) with a
//  1-clk valid strobe, and flags malformed frames.
// PARAMETERS
//  FRAME_BITS  11   data bits per frame (bit FRAME_BITS-1 = sign, rest = magnitude)
//  TIMEOUT     255  max clk cycles between rising sclk edges while ncs is low
// PORTS
//  clk        in   1   40 MHz system clock
//  reset      in   1   asynchronous, active-high reset
//  sclk       in   1   SPI clock from master, async to clk, <= 2.5 MHz
//  ncs        in   1   SPI chip select from master, active-low, async
//  mosi       in   1   SPI data from master, async
//  sample     out  11  last good frame, sign-magnitude {sign, mag[9:0]}
//  dac_code   out  11  offset binary of sample (1024 = zero)
//  valid      out  1   1-clk pulse when sample/dac_code update
//  frame_err  out  1   1-clk pulse on a malformed/aborted frame
//  frame_cnt  out  8   count of good frames, wraps 255 -> 0
// BEHAVIOUR
//  Reset, clk, sync: reset is asynchronous, active-high; clk is the 40 MHz clock
//   - reset values: sample=0, dac_code=1024, valid=0, frame_err=0, frame_cnt=0, state=RESYNC
//   - sclk, ncs, mosi each pass through a 2-FF synchronizer, then a 1-FF delay for edge detect
//   - ncs sync/delay FFs reset to 1; sclk and mosi FFs reset to 0
//   - all edge decisions use synchronized signals only
//  FSM states:
//   - RESYNC:   wait for ncs_s==1, then -> IDLE (no false frame if ncs is low at reset release)
//   - IDLE:     ncs_s falling edge -> SHIFT; clear bit_cnt, shift reg, timer
//   - SHIFT:    on each sclk_s rising edge: shreg <= {shreg[FRAME_BITS-2:0], mosi_s};
//               bit_cnt++; timer cleared. Sampling uses synchronized mosi at the detected edge.
//               Master changes mosi on sclk falling edge, so data is stable >= half a period.
//               bit_cnt reaches FRAME_BITS -> WAIT_END.
//               ncs_s rising while bit_cnt<FRAME_BITS -> frame_err pulse, -> IDLE.
//   - WAIT_END: ncs_s rising -> commit: sample<=shreg, dac_code<=conv(shreg), valid pulse,
//               frame_cnt++, -> IDLE. Any further sclk_s rising edge -> ERROR.
//   - ERROR:    frame_err pulses once on entry; wait for ncs_s rising -> IDLE. No commit.
//   - timeout:  in SHIFT or WAIT_END, timer counts clk cycles with no sclk_s rising edge.
//               timer==TIMEOUT -> ERROR (frame_err pulse).
//  Precedence in the same clk:
//   - ncs_s rising wins over sclk_s rising.
//   - In SHIFT with bit_cnt==FRAME_BITS-1, a final sclk edge plus ncs rise is a short frame (err).
//  Conversion, with s=shreg[10], m=shreg[9:0]:
//   - dac_code = s ? 1024-m : 1024+m
//   - Range is 1..2047, so no saturation is needed. Negative zero (0x400) -> 1024.
//  Outputs:
//   - registered; sample/dac_code hold between frames and on error
//   - valid and frame_err are never high in the same cycle
//  Latency: valid asserts 4 clk edges after the ncs pin rises (2 sync + 1 delay + 1 output reg).
//  Frame rate: back-to-back frames with >= 4 clk of ncs high between them are all accepted.
//  Reset mid-frame: partial frame discarded, no valid/frame_err, state RESYNC.
// TESTING
//  1 frame 11'h405 at 625 kHz sclk -> valid 1 clk; sample=11'h405, dac_code=1019, frame_cnt=1
//  2 frames 11'h3FF then 11'h7FF -> dac_code 2047 then 1; frame_cnt=2; 0x400 -> 1024
//  3 7-bit frame after good 11'h123 -> frame_err 1 clk; no valid; sample stays 11'h123
//  4 12 sclk edges in one frame -> frame_err on 12th edge only; no valid; cnt unchanged
//  5 ncs low, sclk stops after 5 bits for 300 clk -> frame_err at TIMEOUT; next frame good
//  6 reset pulse mid-frame, ncs held low -> no valid/err; ncs high, then 11'h011 -> valid
//    frame_cnt=1; then 256 good frames -> frame_cnt wraps to 1

Source files
------------

// File: rtl/spi_sample_rx.sv
// spi_sample_rx: mode-0 SPI slave for sign-magnitude audio frames.
// Pins are oversampled on clk; good frames also yield an offset-binary DAC code.
module spi_sample_rx #(
   parameter int unsigned FRAME_BITS = 11,
   parameter int unsigned TIMEOUT    = 255
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  sclk,
   input  logic                  ncs,
   input  logic                  mosi,
   output logic [FRAME_BITS-1:0] sample,
   output logic [FRAME_BITS-1:0] dac_code,
   output logic                  valid,
   output logic                  frame_err,
   output logic [7:0]            frame_cnt
);

   localparam int unsigned CW = $clog2(FRAME_BITS + 1);
   localparam int unsigned TW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LAST = CW'(FRAME_BITS - 1);
   localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);
   localparam logic [FRAME_BITS-1:0] MID =
      {1'b1, {(FRAME_BITS-1){1'b0}}};

   typedef enum logic [2:0] {
      RESYNC,
      IDLE,
      SHIFT,
      WAIT_END,
      ERROR
   } state_t;

   logic [2:0] sclk_q;
   logic [2:0] ncs_q;
   logic [1:0] mosi_q;

   logic sclk_rise;
   logic ncs_s;
   logic ncs_rise;
   logic ncs_fall;
   logic mosi_s;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sclk_q <= '0;
         ncs_q  <= '1;
         mosi_q <= '0;
      end else begin
         sclk_q <= {sclk_q[1:0], sclk};
         ncs_q  <= {ncs_q[1:0], ncs};
         mosi_q <= {mosi_q[0], mosi};
      end
   end

   assign sclk_rise = sclk_q[1] & ~sclk_q[2];
   assign ncs_s     = ncs_q[1];
   assign ncs_rise  = ncs_q[1] & ~ncs_q[2];
   assign ncs_fall  = ~ncs_q[1] & ncs_q[2];
   assign mosi_s    = mosi_q[1];

   state_t                state_q;
   logic [1:0]            settle_q;
   logic [CW-1:0]         bit_cnt_q;
   logic [TW-1:0]         timer_q;
   logic [FRAME_BITS-1:0] shreg_q;
   logic [FRAME_BITS-1:0] data_q;
   logic                  commit_q;
   logic                  err_q;

   // settle_q lets the synchronizer fill with the real ncs level before
   // RESYNC trusts it, so a low ncs at reset release never opens a frame
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= RESYNC;
         settle_q  <= '0;
         bit_cnt_q <= '0;
         timer_q   <= '0;
         shreg_q   <= '0;
         data_q    <= '0;
         commit_q  <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         commit_q <= 1'b0;
         err_q    <= 1'b0;
         unique case (state_q)
            RESYNC: begin
               if (settle_q != 2'd3) begin
                  settle_q <= settle_q + 2'd1;
               end else if (ncs_s) begin
                  state_q <= IDLE;
               end
            end
            IDLE: begin
               if (ncs_fall) begin
                  bit_cnt_q <= '0;
                  shreg_q   <= '0;
                  timer_q   <= '0;
                  state_q   <= SHIFT;
               end
            end
            SHIFT: begin
               if (ncs_rise) begin
                  err_q   <= 1'b1;
                  state_q <= IDLE;
               end else if (sclk_rise) begin
                  shreg_q   <= {shreg_q[FRAME_BITS-2:0], mosi_s};
                  bit_cnt_q <= bit_cnt_q + CW'(1);
                  timer_q   <= '0;
                  if (bit_cnt_q == LAST) begin
                     state_q <= WAIT_END;
                  end
               end else if (timer_q == TMAX) begin
                  err_q   <= 1'b1;
                  state_q <= ERROR;
               end else begin
                  timer_q <= timer_q + TW'(1);
               end
            end
            WAIT_END: begin
               if (ncs_rise) begin
                  data_q   <= shreg_q;
                  commit_q <= 1'b1;
                  state_q  <= IDLE;
               end else if (sclk_rise || timer_q == TMAX) begin
                  err_q   <= 1'b1;
                  state_q <= ERROR;
               end else begin
                  timer_q <= timer_q + TW'(1);
               end
            end
            ERROR: begin
               if (ncs_s) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= RESYNC;
         endcase
      end
   end

   logic [FRAME_BITS-1:0] mag;
   logic [FRAME_BITS-1:0] dac_d;

   assign mag = {1'b0, data_q[FRAME_BITS-2:0]};

   always_comb begin
      dac_d = MID + mag;
      if (data_q[FRAME_BITS-1]) begin
         dac_d = MID - mag;
      end
   end

   logic [FRAME_BITS-1:0] sample_q;
   logic [FRAME_BITS-1:0] dac_q;
   logic                  valid_q;
   logic                  ferr_q;
   logic [7:0]            cnt_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sample_q <= '0;
         dac_q    <= MID;
         valid_q  <= 1'b0;
         ferr_q   <= 1'b0;
         cnt_q    <= '0;
      end else begin
         valid_q <= commit_q;
         ferr_q  <= err_q;
         if (commit_q) begin
            sample_q <= data_q;
            dac_q    <= dac_d;
            cnt_q    <= cnt_q + 8'd1;
         end
      end
   end

   assign sample    = sample_q;
   assign dac_code  = dac_q;
   assign valid     = valid_q;
   assign frame_err = ferr_q;
   assign frame_cnt = cnt_q;

endmodule
